bistable_state_detector: RTL
============================

Name: bistable_state_detector

Overview:
- Sits directly downstream of the ADC pass-through stage and consumes its 16-bit two's-complement sample stream, one sample per ADC clock.
- Classifies the signal into one of two wells (LOW/HIGH) using hysteresis thresholds and a debounce requirement.
- Measures the residence time in each well and reports each completed dwell with a one-cycle strobe, for Boltzmann/Kramers statistics.

Parameters:
DW, 16, sample and threshold width (signed two's complement)
CW, 32, residence-counter and dwell-output width
DEBOUNCE, 4, consecutive qualifying samples required to switch well (legal range 1..255)

Ports:
adc_clk_i  in  1  ADC clock; all logic on the rising edge
adc_rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  synchronous run enable; low forces INIT and clears counters
adc_data_i  in  DW  signed sample from the upstream stage
thr_hi_i  in  DW  signed upper threshold (enter HIGH when sample > thr_hi_i)
thr_lo_i  in  DW  signed lower threshold (enter LOW when sample < thr_lo_i)
state_o  out  2  00=INIT, 01=LOW, 10=HIGH (11 never driven)
dwell_o  out  CW  duration of the last completed LOW/HIGH residence, in cycles
dwell_valid_o  out  1  one-cycle strobe; dwell_o is new this cycle
dwell_level_o  out  1  well that dwell_o describes (0=LOW, 1=HIGH)
trans_cnt_o  out  CW  count of LOW<->HIGH transitions, wraps modulo 2^CW

Behaviour:
- Reset (async, adc_rstn_i=0): all outputs 0, state INIT, s_q=0, deb_cnt=0, res_cnt=0. Release is synchronous to the next edge.
- Input stage: s_q <= adc_data_i on every edge. All comparisons use s_q, signed.
- Qualifiers: up = s_q > thr_hi_i; dn = s_q < thr_lo_i.
- Threshold validity: if thr_lo_i > thr_hi_i, thresholds are invalid. In that case up and dn are forced to 0, deb_cnt is cleared and the state holds.
- Threshold changes take effect on the next comparison; there is no shadowing.
- Debounce: deb_cnt counts consecutive edges on which the exit qualifier for the current state is true:
  - LOW: up.
  - HIGH: dn.
  - INIT: up or dn, restarting if the qualifying direction changes.
  - It clears to 0 whenever the qualifier is false.
  - The transition fires on the edge where the qualifier is true and deb_cnt == DEBOUNCE-1; deb_cnt clears on that edge.
- Latency: if adc_data_i qualifies at edges k..k+DEBOUNCE-1, state_o changes at edge k+DEBOUNCE. With DEBOUNCE=1, latency is 1 cycle from input to state_o.
- State transitions:
  - INIT->HIGH on debounced up.
  - INIT->LOW on debounced dn.
  - LOW->HIGH on debounced up.
  - HIGH->LOW on debounced dn.
  - No other transitions.
- Residence counter:
  - res_cnt <= 0 on every state-entry edge.
  - Otherwise, in LOW/HIGH, res_cnt increments each edge and saturates at 2^CW-1.
  - In INIT it stays 0.
- Dwell reporting on a LOW<->HIGH transition edge:
  - dwell_o <= res_cnt+1, saturating at 2^CW-1.
  - dwell_level_o <= old state (HIGH=1).
  - dwell_valid_o <= 1 for exactly one cycle.
  - trans_cnt_o <= trans_cnt_o+1 (wraps).
- Exits from INIT produce no dwell strobe and no trans_cnt_o increment.
- dwell_o and dwell_level_o hold their values until the next report.
- enable_i=0: on the next edge, state INIT, deb_cnt=0, res_cnt=0, dwell_valid_o=0 and trans_cnt_o=0. dwell_o and dwell_level_o hold. s_q keeps sampling.
- Re-enable resumes from INIT. Any partial residence is discarded.
- Reset asserted mid-dwell: the dwell is discarded, with no strobe.

Test Plan:
- DEBOUNCE=4, thr_hi=1000, thr_lo=-1000, after reset/enable: drive 2000 for 4 cycles -> state_o=HIGH exactly 4 edges after first sample; no dwell_valid_o; trans_cnt_o=0.
- From HIGH, drive 0 for 50 cycles then -2000 for 4 cycles -> state_o=LOW; one dwell_valid_o pulse with dwell_o=54 cycles of HIGH residence counted from entry edge (verify against the bench model), dwell_level_o=1, trans_cnt_o=1.
- Glitch rejection: in LOW, drive 2000 for 3 cycles, 500 for 1 cycle, 2000 for 3 cycles -> no transition, no strobe.
- Invalid thresholds (thr_lo=500, thr_hi=-500) with full-scale ±32767 toggling -> state held, no strobes. Restoring valid thresholds resumes detection.
- CW=8 build: hold LOW for 300 cycles then switch -> dwell_o=255 (saturated). Force 257 transitions -> trans_cnt_o=1 (wrapped).
- Drop enable_i mid-dwell and assert adc_rstn_i mid-dwell in separate runs -> state_o=INIT, no dwell strobe. Next debounced crossing leaves INIT without a strobe.

Source files
------------

// File: rtl/bistable_state_detector.sv
// Two-well hysteresis classifier with debounce; reports each completed LOW/HIGH
// residence time and counts well-to-well transitions.
module bistable_state_detector #(
  parameter int DW       = 16,
  parameter int CW       = 32,
  parameter int DEBOUNCE = 4
) (
  input  logic                 adc_clk_i,
  input  logic                 adc_rstn_i,
  input  logic                 enable_i,
  input  logic signed [DW-1:0] adc_data_i,
  input  logic signed [DW-1:0] thr_hi_i,
  input  logic signed [DW-1:0] thr_lo_i,
  output logic [1:0]           state_o,
  output logic [CW-1:0]        dwell_o,
  output logic                 dwell_valid_o,
  output logic                 dwell_level_o,
  output logic [CW-1:0]        trans_cnt_o
);

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_t;

  localparam logic [7:0]    DEB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t                state_q, state_d;
  logic signed [DW-1:0]  s_q;
  logic [7:0]            deb_cnt, deb_d, deb_base;
  logic                  dir_q, dir_d;
  logic [CW-1:0]         res_cnt, res_d, res_inc;
  logic                  thr_ok, up, dn, qual, entry, report;

  always_comb begin
    thr_ok = !(thr_lo_i > thr_hi_i);
    up     = thr_ok && (s_q > thr_hi_i);
    dn     = thr_ok && (s_q < thr_lo_i);
  end

  always_comb begin
    state_d  = state_q;
    deb_d    = '0;
    deb_base = deb_cnt;
    dir_d    = dir_q;
    qual     = 1'b0;
    case (state_q)
      ST_INIT: begin
        qual = up | dn;
        if (qual) begin
          dir_d = up;
          // a change of direction in INIT restarts the run from this sample
          if (deb_cnt != '0 && dir_q != up) deb_base = '0;
        end
      end
      ST_LOW:  qual = up;
      ST_HIGH: qual = dn;
      default: state_d = ST_INIT;
    endcase
    if (qual) begin
      if (deb_base == DEB_LAST) begin
        state_d = up ? ST_HIGH : ST_LOW;
        deb_d   = '0;
      end else begin
        deb_d = deb_base + 8'd1;
      end
    end

    res_inc = (res_cnt == CNT_MAX) ? res_cnt : res_cnt + {{(CW-1){1'b0}}, 1'b1};
    entry   = (state_d != state_q);
    report  = entry && (state_q == ST_LOW || state_q == ST_HIGH);
    res_d   = (entry || state_q == ST_INIT) ? '0 : res_inc;
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q       <= ST_INIT;
      s_q           <= '0;
      deb_cnt       <= '0;
      dir_q         <= 1'b0;
      res_cnt       <= '0;
      dwell_o       <= '0;
      dwell_valid_o <= 1'b0;
      dwell_level_o <= 1'b0;
      trans_cnt_o   <= '0;
    end else begin
      s_q <= adc_data_i;
      if (!enable_i) begin
        state_q       <= ST_INIT;
        deb_cnt       <= '0;
        dir_q         <= 1'b0;
        res_cnt       <= '0;
        dwell_valid_o <= 1'b0;
        trans_cnt_o   <= '0;
      end else begin
        state_q       <= state_d;
        deb_cnt       <= deb_d;
        dir_q         <= dir_d;
        res_cnt       <= res_d;
        dwell_valid_o <= report;
        if (report) begin
          dwell_o       <= res_inc;
          dwell_level_o <= (state_q == ST_HIGH);
          trans_cnt_o   <= trans_cnt_o + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign state_o = state_q;

endmodule
